instr_fetch: RTL and testbench

- Fetch stage of the 8-bit single-issue CPU. It sits directly upstream of the instruction decoder and control unit.
- Owns the program counter and issues reads to a synchronous instruction memory with 1-cycle latency.
- Buffers returned instructions, tagged with their PC, and hands them to decode over a valid/ready handshake.
- Accepts redirects from the branch-resolution logic (opcode 2'b11 compare result).

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/fetch_buffer.sv | 68 ++++++
 rtl/instr_fetch.sv | 87 ++++++++
 tb/tb_instr_fetch.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared types and constants for the 8-bit single-issue CPU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int c_PC_W = 8;
    localparam int c_IW   = 8;

    localparam logic [1:0] OP_RTYPE = 2'b00;
    localparam logic [1:0] OP_LW    = 2'b01;
    localparam logic [1:0] OP_SW    = 2'b10;
    localparam logic [1:0] OP_BEQ   = 2'b11;

    typedef struct packed {
        logic [c_IW-1:0]   instr;
        logic [c_PC_W-1:0] pc;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// Module : fetch_buffer
// Brief  : DEPTH-entry circular FIFO with push, pop and single-cycle flush.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic [WIDTH-1:0]             o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Explicit wrap so non-power-of-two depths work too.
    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH-1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= f_next(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module : instr_fetch
// Brief  : Fetch stage: PC, credit-based imem reads, redirect, decode handoff.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_fetch
    import cpu_pkg::*;
#(
    parameter int PC_W  = c_PC_W,
    parameter int IW    = c_IW,
    parameter int DEPTH = 2
) (
    input  logic            CLK,
    input  logic            RESETN,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [IW-1:0]   imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IW-1:0]   out_instr,
    output logic [PC_W-1:0] out_pc,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc
);

    localparam int c_CNT_W = $clog2(DEPTH+1);
    localparam int c_EW    = IW + PC_W;

    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_issue_pc;
    logic               r_inflight;

    logic [c_CNT_W-1:0] w_count;
    logic [c_EW-1:0]    w_head;
    logic               w_pop;
    logic               w_push;
    logic [c_CNT_W:0]   w_occ;
    logic               w_credit;

    assign out_valid = (w_count != '0);
    assign w_pop     = out_valid & out_ready & ~redirect;
    assign w_push    = r_inflight & ~redirect;

    // Entries held plus the one in flight, less the one leaving this cycle.
    assign w_occ    = {1'b0, w_count} + (c_CNT_W+1)'(r_inflight) - (c_CNT_W+1)'(w_pop);
    assign w_credit = (w_occ < (c_CNT_W+1)'(DEPTH));

    // RESETN gates the strobe so no read escapes while the stage is held in reset.
    assign imem_en   = RESETN & (redirect | w_credit);
    assign imem_addr = redirect ? redirect_pc : r_pc;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_pc       <= '0;
            r_issue_pc <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= imem_en;
            if (imem_en) begin
                r_issue_pc <= imem_addr;
                r_pc       <= imem_addr + PC_W'(1);
            end
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (c_EW)
    ) u_fetch_buffer (
        .clk         (CLK),
        .rst_n       (RESETN),
        .i_push      (w_push),
        .i_push_data ({imem_rdata, r_issue_pc}),
        .i_pop       (w_pop),
        .i_flush     (redirect),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign out_instr = w_head[c_EW-1:PC_W];
    assign out_pc    = w_head[PC_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module : tb_instr_fetch
// Brief  : Scoreboard bench for instr_fetch with a mem[a]=a^8'h5A memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;
    import cpu_pkg::*;

    logic       CLK;
    logic       RESETN;
    logic       imem_en;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_instr;
    logic [7:0] out_pc;
    logic       redirect;
    logic [7:0] redirect_pc;

    int checks = 0;
    int errors = 0;
    fetch_entry_t exp_q[$];

    instr_fetch #(.PC_W(8), .IW(8), .DEPTH(2)) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial imem_rdata = 8'h00;
    always @(posedge CLK) begin
        if (imem_en) imem_rdata <= imem_addr ^ 8'h5A;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_e(input logic [7:0] pc, input logic [7:0] instr);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted, non-voided head transfer must match the scoreboard.
    always @(negedge CLK) begin
        #2;
        if (out_valid === 1'b1 && out_ready === 1'b1 && redirect === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got pc %0h instr %0h expected none", out_pc, out_instr);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                chk("xfer_pc", 32'(out_pc), 32'(e.pc));
                chk("xfer_instr", 32'(out_instr), 32'(e.instr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESETN = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        repeat (3) @(negedge CLK);
        #2;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_en", 32'(imem_en), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_instr", 32'(out_instr), 0);
        chk("rst_pc", 32'(out_pc), 0);

        // Streaming from reset with ready held high.
        @(negedge CLK); RESETN = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) expect_e(8'(k), 8'(k) ^ 8'h5A);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge CLK);
            #2;
            chk("stream_en", 32'(imem_en), 1);
            chk("stream_addr", 32'(imem_addr), 32'(k));
        end
        @(negedge CLK); #1 RESETN = 1'b0; #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_en", 32'(imem_en), 0);
        chk("stream_drained", 32'(exp_q.size()), 0);

        // Backpressure: buffer fills, head holds, then drains in order.
        repeat (2) @(negedge CLK);
        @(negedge CLK); RESETN = 1'b1; out_ready = 1'b0;
        expect_e(8'h00, 8'h5A); expect_e(8'h01, 8'h5B); expect_e(8'h02, 8'h58);
        #2;
        chk("restart_en", 32'(imem_en), 1);
        chk("restart_addr", 32'(imem_addr), 0);
        @(negedge CLK);
        @(negedge CLK); #2;
        chk("bp_first_valid", 32'(out_valid), 1);
        chk("bp_first_instr", 32'(out_instr), 32'h5A);
        chk("bp_first_pc", 32'(out_pc), 0);
        chk("bp_no_issue_c2", 32'(imem_en), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK); #2;
            chk("bp_full_en", 32'(imem_en), 0);
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_instr", 32'(out_instr), 32'h5A);
            chk("bp_hold_pc", 32'(out_pc), 0);
        end
        @(negedge CLK); out_ready = 1'b1; #2;
        chk("bp_resume_en", 32'(imem_en), 1);
        chk("bp_resume_addr", 32'(imem_addr), 2);
        repeat (2) @(negedge CLK);
        @(negedge CLK); #1 RESETN = 1'b0; #1;
        chk("bp_drained", 32'(exp_q.size()), 0);

        // Redirect with an entry buffered and a read in flight.
        repeat (2) @(negedge CLK);
        @(negedge CLK); RESETN = 1'b1; out_ready = 1'b0;
        @(negedge CLK);
        @(negedge CLK); redirect = 1'b1; redirect_pc = 8'h40; #2;
        chk("redir_en", 32'(imem_en), 1);
        chk("redir_addr", 32'(imem_addr), 32'h40);
        @(negedge CLK); redirect = 1'b0; out_ready = 1'b1;
        expect_e(8'h40, 8'h1A); expect_e(8'h41, 8'h1B); expect_e(8'h42, 8'h18);
        #2;
        chk("redir_flushed", 32'(out_valid), 0);
        @(negedge CLK); #2;
        chk("redir_target_valid", 32'(out_valid), 1);
        chk("redir_target_pc", 32'(out_pc), 32'h40);
        repeat (2) @(negedge CLK);

        // Back-to-back redirects: only the last target survives.
        @(negedge CLK); redirect = 1'b1; redirect_pc = 8'h10; #2;
        chk("redir_drained", 32'(exp_q.size()), 0);
        chk("b2b_addr0", 32'(imem_addr), 32'h10);
        @(negedge CLK); redirect_pc = 8'h20; #2;
        chk("b2b_addr1", 32'(imem_addr), 32'h20);
        expect_e(8'h20, 8'h7A); expect_e(8'h21, 8'h7B);
        @(negedge CLK); redirect = 1'b0;
        repeat (2) @(negedge CLK);

        // Redirect to the top of the address space: PC wraps to 0.
        @(negedge CLK); redirect = 1'b1; redirect_pc = 8'hFF; #2;
        chk("b2b_drained", 32'(exp_q.size()), 0);
        chk("wrap_redir_addr", 32'(imem_addr), 32'hFF);
        expect_e(8'hFF, 8'hA5); expect_e(8'h00, 8'h5A); expect_e(8'h01, 8'h5B);
        @(negedge CLK); redirect = 1'b0; #2;
        chk("wrap_issue_addr", 32'(imem_addr), 0);
        repeat (3) @(negedge CLK);
        @(negedge CLK); #1 RESETN = 1'b0; #1;
        chk("wrap_drained", 32'(exp_q.size()), 0);
        chk("final_rst_valid", 32'(out_valid), 0);

        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
